reg_bank_ctrl: RTL

Two-requester controller that shares the 8x8 register bank between two datapath clients (e.g. ALU writeback and load/debug unit). It arbitrates requests, drives the bank's select/write/data inputs with registered signals, and returns the captured read operands with a done pulse. It sits between the requesters and the register bank. The bank's write address is its X-select field.

---
 rtl/reg_bank_ctrl_pkg.sv | 23 ++
 rtl/reg_bank_ctrl_rr_arb2.sv | 68 ++++++
 rtl/reg_bank_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/reg_bank_ctrl_pkg.sv
// Shared types and constants for the register bank controller.
// Optional feature macro: REG_BANK_CTRL_RR_EN (round-robin arbitration).
package reg_bank_ctrl_pkg;

    localparam int NUM_REQ    = 2;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // One requester command at the default widths.
    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] xa;
        logic [DEF_ADDR_W-1:0] ya;
        logic [DEF_DATA_W-1:0] wd;
    } cmd_t;

endpackage

// File: rtl/reg_bank_ctrl_rr_arb2.sv
// Two-way arbiter producing a one-hot winner.
// With REG_BANK_CTRL_RR_EN defined a 1-bit pointer rotates priority to the
// requester that was not served; otherwise requester 0 has fixed priority.
module rr_arb2
    import reg_bank_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] win_o
);

`ifdef REG_BANK_CTRL_RR_EN
    logic ptr_q;
    logic ptr_d;

    // Pick the winner; on a tie the pointer decides, and after any grant the pointer moves to the other requester.
    always_comb begin
        win_o = 2'b00;
        ptr_d = ptr_q;
        if (req_i[0] && req_i[1]) begin
            if (ptr_q) begin
                win_o = 2'b10;
            end else begin
                win_o = 2'b01;
            end
        end else if (req_i[0]) begin
            win_o = 2'b01;
        end else if (req_i[1]) begin
            win_o = 2'b10;
        end else begin
            win_o = 2'b00;
        end
        if (win_o[0]) begin
            ptr_d = 1'b1;
        end else if (win_o[1]) begin
            ptr_d = 1'b0;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register; reset favours requester 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_clk_rst_s;
    assign unused_clk_rst_s = clk ^ rst;

    // Fixed priority: requester 0 always wins when it asks.
    always_comb begin
        win_o = 2'b00;
        if (req_i[0]) begin
            win_o = 2'b01;
        end else if (req_i[1]) begin
            win_o = 2'b10;
        end else begin
            win_o = 2'b00;
        end
    end
`endif

endmodule

// File: rtl/reg_bank_ctrl.sv
// Two-requester controller for the 8x8 register bank: arbitrates, drives the
// bank with registered select/write/data for one ACCESS cycle, captures the
// read operands and pulses done to the served requester.
// Optional feature macro: REG_BANK_CTRL_RR_EN (round-robin instead of fixed priority).
module reg_bank_ctrl
    import reg_bank_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_0,
    input  logic                req_1,
    input  logic                we_0,
    input  logic                we_1,
    input  logic [ADDR_W-1:0]   xa_0,
    input  logic [ADDR_W-1:0]   xa_1,
    input  logic [ADDR_W-1:0]   ya_0,
    input  logic [ADDR_W-1:0]   ya_1,
    input  logic [DATA_W-1:0]   wd_0,
    input  logic [DATA_W-1:0]   wd_1,
    output logic                gnt_0,
    output logic                gnt_1,
    output logic                done_0,
    output logic                done_1,
    output logic [DATA_W-1:0]   rdx,
    output logic [DATA_W-1:0]   rdy,
    output logic                busy,
    output logic [2*ADDR_W-1:0] bk_sel,
    output logic                bk_w,
    output logic [DATA_W-1:0]   bk_dw,
    input  logic [DATA_W-1:0]   bk_rx,
    input  logic [DATA_W-1:0]   bk_ry
);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          done_q, done_d;
    logic                busy_q, busy_d;
    logic [2*ADDR_W-1:0] sel_q, sel_d;
    logic                w_q, w_d;
    logic [DATA_W-1:0]   dw_q, dw_d;
    logic [DATA_W-1:0]   rdx_q, rdx_d;
    logic [DATA_W-1:0]   rdy_q, rdy_d;

    logic                arb_en_s;
    logic [1:0]          req_s;
    logic [1:0]          win_s;

    // Requests are only visible to the arbiter at arbitration edges (IDLE or DONE).
    assign arb_en_s = (state_q == IDLE) || (state_q == DONE);
    assign req_s    = {req_1, req_0} & {2{arb_en_s}};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_s),
        .win_o (win_s)
    );

    // Next state; the winning command is loaded straight into the bank drive registers so they are valid throughout ACCESS.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        busy_d  = 1'b0;
        sel_d   = '0;
        w_d     = 1'b0;
        dw_d    = '0;
        rdx_d   = rdx_q;
        rdy_d   = rdy_q;
        case (state_q)
            IDLE, DONE: begin
                if (win_s != 2'b00) begin
                    state_d = ACCESS;
                    gnt_d   = win_s;
                    owner_d = win_s[1];
                    busy_d  = 1'b1;
                    if (win_s[1]) begin
                        sel_d = {ya_1, xa_1};
                        w_d   = we_1;
                        dw_d  = wd_1;
                    end else begin
                        sel_d = {ya_0, xa_0};
                        w_d   = we_0;
                        dw_d  = wd_0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // Bank reads are combinational, so this captures pre-write values.
                state_d = DONE;
                busy_d  = 1'b1;
                rdx_d   = bk_rx;
                rdy_d   = bk_ry;
                if (owner_q) begin
                    done_d = 2'b10;
                end else begin
                    done_d = 2'b01;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
            sel_q   <= '0;
            w_q     <= 1'b0;
            dw_q    <= '0;
            rdx_q   <= '0;
            rdy_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            sel_q   <= sel_d;
            w_q     <= w_d;
            dw_q    <= dw_d;
            rdx_q   <= rdx_d;
            rdy_q   <= rdy_d;
        end
    end

    assign gnt_0  = gnt_q[0];
    assign gnt_1  = gnt_q[1];
    assign done_0 = done_q[0];
    assign done_1 = done_q[1];
    assign busy   = busy_q;
    assign bk_sel = sel_q;
    assign bk_w   = w_q;
    assign bk_dw  = dw_q;
    assign rdx    = rdx_q;
    assign rdy    = rdy_q;

endmodule
